// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, defaults and helpers for the convolution write-back path
package conv_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 12;

  localparam logic [2:0] KER_SIZE_2 = 3'd2;
  localparam logic [2:0] KER_SIZE_3 = 3'd3;
  localparam logic [2:0] KER_SIZE_5 = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wb_state_t;

  // Side of the valid-convolution output map; caller guarantees ker <= img.
  function automatic logic [4:0] out_dim(input logic [4:0] img, input logic [2:0] ker);
    return img - {2'b00, ker} + 5'd1;
  endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// rtl/wb_sync_fifo.sv - synchronous result FIFO with flush and a flop-held head word
module wb_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_writeback_unit.sv
// rtl/result_writeback_unit.sv - buffers PE results and writes them row-major to BRAM
// Optional clamp of negative results to zero is enabled by defining WB_RELU_EN.
module result_writeback_unit
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int MAX_IMG_WIDTH = 28,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] out_base_addr,
  input  logic [2:0]            ker_size,
  input  logic [4:0]            img_size,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_dout,
  input  logic                  bram_gnt,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  cfg_err
);

  localparam logic [5:0] MAX_IMG = 6'(MAX_IMG_WIDTH);

  wb_state_t             state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [9:0]            expected;
  logic [9:0]            accepted;
  logic [9:0]            written;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] head;
  logic                  cfg_bad;
  logic [4:0]            od;

  assign cfg_bad = (ker_size == 3'd0) || ({2'b00, ker_size} > img_size) ||
                   ({1'b0, img_size} > MAX_IMG);
  assign od      = out_dim(img_size, ker_size);

  assign bram_we   = !fifo_empty;
  assign bram_dout = head;
  assign bram_addr = base_q + ADDR_WIDTH'(written);
  assign busy      = (state != IDLE);

  assign pop  = bram_we && bram_gnt;
  assign push = (state == RUN) && !start && res_valid && (!fifo_full || pop) &&
                (accepted < expected);

`ifdef WB_RELU_EN
  assign push_data = res_data[DATA_WIDTH-1] ? '0 : res_data;
`else
  assign push_data = res_data;
`endif

  wb_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (start),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      base_q     <= '0;
      expected   <= '0;
      accepted   <= '0;
      written    <= '0;
      overflow   <= 1'b0;
      cfg_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start) begin
        // A start in any state abandons the current frame without a done pulse.
        base_q   <= out_base_addr;
        expected <= {5'd0, od} * {5'd0, od};
        accepted <= '0;
        written  <= '0;
        overflow <= 1'b0;
        if (cfg_bad) begin
          cfg_err    <= 1'b1;
          frame_done <= 1'b1;
          state      <= DONE;
        end else begin
          cfg_err <= 1'b0;
          state   <= RUN;
        end
      end else begin
        if (push) accepted <= accepted + 10'd1;
        if (pop)  written  <= written + 10'd1;
        case (state)
          RUN: begin
            if (res_valid && !push) overflow <= 1'b1;
            if (push && (accepted + 10'd1 == expected)) state <= DRAIN;
          end
          DRAIN: begin
            if (pop && (written + 10'd1 == expected)) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/result_writeback_unit.md
Name: result_writeback_unit

Overview:
- Write-side counterpart of the image fetch path. Accepts convolution results from the PE array (one word per res_valid pulse) and buffers them in a small FIFO.
- Writes results row-major into the output feature map region of BRAM through a granted write port.
- Signals frame_done once all (img_size-ker_size+1)^2 results of a frame are committed to BRAM.

Parameters:
- DATA_WIDTH, 32, result word width and BRAM data width
- ADDR_WIDTH, 12, BRAM address width
- MAX_IMG_WIDTH, 28, largest supported input image side
- FIFO_DEPTH, 8, result buffer depth (power of two, >=2)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latch config, begin frame
- out_base_addr  in  ADDR_WIDTH  first output word address
- ker_size  in  3  kernel side (2, 3 or 5)
- img_size  in  5  input image side
- res_valid  in  1  result word present on res_data
- res_data  in  DATA_WIDTH  PE result
- bram_we  out  1  write request
- bram_addr  out  ADDR_WIDTH  write address
- bram_dout  out  DATA_WIDTH  write data
- bram_gnt  in  1  write accepted this cycle when bram_we=1
- busy  out  1  high from start until frame_done
- frame_done  out  1  one-cycle pulse, all results written
- overflow  out  1  sticky; result dropped (FIFO full or excess); cleared by start
- cfg_err  out  1  sticky; illegal config; cleared by start

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, counters 0.
- Config on start: out_dim = img_size - ker_size + 1; expected = out_dim*out_dim (10 bits, max 784). Stored in registers.
- Illegal config: ker_size==0 or ker_size>img_size or img_size>MAX_IMG_WIDTH. Sets cfg_err, pulses frame_done the next cycle, returns to IDLE and writes nothing.
- FSM states:
  - IDLE -> RUN on a legal start.
  - RUN -> DRAIN when accepted count reaches expected.
  - DRAIN -> DONE when written count reaches expected.
  - DONE pulses frame_done for one cycle, then goes to IDLE.
  - busy = (state != IDLE).
- Accept rule: push when state==RUN && res_valid && (!full || pop this cycle) && accepted<expected.
- Drop rule: res_valid in RUN when the push is blocked sets overflow. res_valid in IDLE, DRAIN or DONE is ignored and does not set overflow.
- Write port: bram_we = !fifo_empty, registered from FIFO head. bram_addr = out_base_addr + written (mod 2^ADDR_WIDTH, wrap allowed).
- Pop occurs on bram_we && bram_gnt. bram_we, bram_addr and bram_dout hold stable until granted.
- Latency: a result accepted in cycle N appears on bram_we/bram_dout in cycle N+1 (empty FIFO). frame_done is asserted the cycle after the final grant.
- Simultaneous push and pop when full: both occur, occupancy unchanged, no overflow.
- start while busy: abort the frame, flush the FIFO, deassert bram_we next cycle, reload config, clear sticky flags. The abandoned frame gets no frame_done.
- Reset mid-frame: immediate return to reset values; no partial write completes.

Optional Feature:
- Macro WB_RELU_EN.
- Defined: each result is clamped to 0 when its sign bit (two's complement) is set, before entering the FIFO. Zero added latency.
- Undefined: data is written unmodified.

Decomposition:
- Package conv_pkg:
  - DATA_WIDTH and ADDR_WIDTH defaults
  - wb_state_t enum {IDLE, RUN, DRAIN, DONE}
  - function out_dim(img, ker)
  - legal kernel-size constants (2, 3, 5)
- One sub-module, wb_sync_fifo:
  - parameterised depth and width
  - push/pop ports, full/empty flags, registered head
  - instantiated once.

Test Plan:
- img=4, ker=3, base=0x100, 4 results 0xA..0xD, gnt=1 -> writes at 0x100..0x103 with data A..D, frame_done one cycle after the last write, busy falls.
- img=28, ker=5, gnt toggling 50%, continuous res_valid at half rate -> exactly 576 writes in order, no overflow, frame_done once.
- FIFO_DEPTH=8, gnt=0 for 20 cycles while 12 results arrive -> first 8 buffered, overflow=1; after gnt=1 exactly 8 writes occur, values intact.
- ker=5, img=3 -> cfg_err=1, frame_done pulse within 2 cycles, bram_we never asserted.
- start mid-frame after 3 of 9 writes (img=5, ker=3), new base 0x200 -> bram_we drops, next writes start at 0x200, and overflow/cfg_err are cleared.
- With WB_RELU_EN: result 0xFFFF_FFF6 -> written as 0; result 0x0000_0005 -> written unchanged.
